gpio_irq: RTL

- Parametrised successor to the 2-pin gpio peripheral, sitting on a RIB slave port.
- Provides GPIO_NUM bidirectional pins with per-pin direction, input synchronisation and programmable debounce.
- Per-pin edge/level interrupts with sticky write-1-to-clear pending bits; one combined interrupt line feeds a bit of int_flag.

---
 rtl/gpio_irq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_irq
// Brief    : RIB-attached GPIO with synchroniser, debounce and per-pin irqs.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_irq #(
  parameter int GPIO_NUM    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  input  logic [GPIO_NUM-1:0] io_pin_i,
  output logic [GPIO_NUM-1:0] io_out_o,
  output logic [GPIO_NUM-1:0] io_oe_o,
  output logic                int_sig_o
);

  localparam logic [5:0] c_a_ctrl  = 6'd0;
  localparam logic [5:0] c_a_data  = 6'd1;
  localparam logic [5:0] c_a_inten = 6'd2;
  localparam logic [5:0] c_a_itype = 6'd3;
  localparam logic [5:0] c_a_pend  = 6'd4;
  localparam logic [5:0] c_a_inraw = 6'd5;
  localparam logic [5:0] c_a_deb   = 6'd6;

  localparam logic [DB_CNT_W-1:0] c_cnt_inc = 1;
  localparam logic [DB_CNT_W:0]   c_cnt_one = 1;

  logic [2*GPIO_NUM-1:0]                r_ctrl;
  logic [GPIO_NUM-1:0]                  r_out;
  logic [GPIO_NUM-1:0]                  r_int_en;
  logic [2*GPIO_NUM-1:0]                r_int_type;
  logic [GPIO_NUM-1:0]                  r_pend;
  logic [DB_CNT_W-1:0]                  r_debounce;
  logic [SYNC_STAGES-1:0][GPIO_NUM-1:0] r_sync;
  logic [GPIO_NUM-1:0]                  r_db;

  logic [GPIO_NUM-1:0] w_sync;
  logic [GPIO_NUM-1:0] w_db_next;
  logic [GPIO_NUM-1:0] w_evt;
  logic [GPIO_NUM-1:0] w_set;
  logic [GPIO_NUM-1:0] w_clr;
  logic [GPIO_NUM-1:0] w_oe;
  logic [GPIO_NUM-1:0] w_data_rd;
  logic [DB_CNT_W-1:0] w_lim;
  logic [31:0]         w_rd;
  logic                w_wr_ctrl, w_wr_data, w_wr_inten, w_wr_itype, w_wr_pend, w_wr_deb;
  logic                w_unused;

  assign w_unused   = ^{addr_i[31:8], addr_i[1:0], data_i};

  assign w_wr_ctrl  = we_i && (addr_i[7:2] == c_a_ctrl);
  assign w_wr_data  = we_i && (addr_i[7:2] == c_a_data);
  assign w_wr_inten = we_i && (addr_i[7:2] == c_a_inten);
  assign w_wr_itype = we_i && (addr_i[7:2] == c_a_itype);
  assign w_wr_pend  = we_i && (addr_i[7:2] == c_a_pend);
  assign w_wr_deb   = we_i && (addr_i[7:2] == c_a_deb);

  assign w_sync = r_sync[SYNC_STAGES-1];
  // D=0 behaves as a single-cycle filter
  assign w_lim  = (r_debounce == '0) ? c_cnt_inc : r_debounce;
  assign w_set  = w_evt & r_int_en;
  assign w_clr  = w_wr_pend ? data_i[GPIO_NUM-1:0] : '0;

  for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
    logic [DB_CNT_W-1:0] r_cnt;
    logic                w_diff, w_hit, w_rise, w_fall, w_in;
    logic [1:0]          w_mode, w_type;

    assign w_mode = r_ctrl[2*i +: 2];
    assign w_type = r_int_type[2*i +: 2];
    assign w_in   = (w_mode == 2'b10);
    assign w_diff = w_sync[i] ^ r_db[i];
    // >= lets a lowered DEBOUNCE value take effect on the very next edge
    assign w_hit  = w_diff && (({1'b0, r_cnt} + c_cnt_one) >= {1'b0, w_lim});
    assign w_db_next[i] = w_hit ? w_sync[i] : r_db[i];

    assign w_rise = ~r_db[i] &  w_db_next[i];
    assign w_fall =  r_db[i] & ~w_db_next[i];
    assign w_evt[i] = w_in && ((w_type == 2'b00) ? w_rise :
                               (w_type == 2'b01) ? w_fall :
                               (w_type == 2'b10) ? (w_rise | w_fall) :
                                                   w_db_next[i]);

    assign w_oe[i]      = (w_mode == 2'b01);
    assign w_data_rd[i] = w_oe[i] ? r_out[i] : (w_in ? r_db[i] : 1'b0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (!w_diff || w_hit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl     <= '0;
      r_out      <= '0;
      r_int_en   <= '0;
      r_int_type <= '0;
      r_pend     <= '0;
      r_debounce <= '0;
      r_sync     <= '0;
      r_db       <= '0;
    end else begin
      if (w_wr_ctrl)  r_ctrl     <= data_i[2*GPIO_NUM-1:0];
      if (w_wr_data)  r_out      <= data_i[GPIO_NUM-1:0];
      if (w_wr_inten) r_int_en   <= data_i[GPIO_NUM-1:0];
      if (w_wr_itype) r_int_type <= data_i[2*GPIO_NUM-1:0];
      if (w_wr_deb)   r_debounce <= data_i[DB_CNT_W-1:0];
      // a new event on the same edge as a clear keeps the bit set
      r_pend <= (r_pend & ~w_clr) | w_set;
      r_sync <= {r_sync[SYNC_STAGES-2:0], io_pin_i};
      r_db   <= w_db_next;
    end
  end

  always_comb begin
    w_rd = '0;
    case (addr_i[7:2])
      c_a_ctrl:  w_rd[2*GPIO_NUM-1:0] = r_ctrl;
      c_a_data:  w_rd[GPIO_NUM-1:0]   = w_data_rd;
      c_a_inten: w_rd[GPIO_NUM-1:0]   = r_int_en;
      c_a_itype: w_rd[2*GPIO_NUM-1:0] = r_int_type;
      c_a_pend:  w_rd[GPIO_NUM-1:0]   = r_pend;
      c_a_inraw: w_rd[GPIO_NUM-1:0]   = w_sync;
      c_a_deb:   w_rd[DB_CNT_W-1:0]   = r_debounce;
      default:   w_rd = '0;
    endcase
  end

  assign data_o    = w_rd;
  assign io_out_o  = r_out;
  assign io_oe_o   = w_oe;
  assign int_sig_o = |(r_pend & r_int_en);

endmodule
`default_nettype wire
